// File: rtl/arch_chk_pkg.sv
// arch_chk_pkg
// Shared types and helpers for the architectural state checker:
//   state_t   - checker FSM states
//   SEL_REG   - selects register-file golden / compare
//   SEL_MEM   - selects data-memory golden / compare
//   idxWidth  - index width for an n-entry table (minimum 1 bit)
package arch_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN_REG,
        ST_SCAN_MEM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    function automatic int idxWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gold_store.sv
// gold_store
// Golden-value storage for the state checker: one array for register-file
// entries and one for data-memory words. Single write port, asynchronous
// read per array. Deliberately has no reset so golden values survive a
// checker reset and a rerun needs no reload.
// Ports:
//   clk          in   write clock
//   reg_we_i     in   write strobe, register golden array
//   mem_we_i     in   write strobe, memory golden array
//   waddr_i      in   write index (shared)
//   wdata_i      in   write data (shared)
//   reg_raddr_i  in   register golden read index
//   mem_raddr_i  in   memory golden read index
//   reg_rdata_o  out  register golden read data
//   mem_rdata_o  out  memory golden read data
module gold_store
    import arch_chk_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREG   = 32,
    parameter int NMEM   = 16,
    localparam int IW    = idxWidth((NREG > NMEM) ? NREG : NMEM),
    localparam int RW    = idxWidth(NREG),
    localparam int MW    = idxWidth(NMEM)
)(
    input  logic              clk,
    input  logic              reg_we_i,
    input  logic              mem_we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [RW-1:0]     reg_raddr_i,
    input  logic [MW-1:0]     mem_raddr_i,
    output logic [DWIDTH-1:0] reg_rdata_o,
    output logic [DWIDTH-1:0] mem_rdata_o
);

    logic [DWIDTH-1:0] regGold [NREG];
    logic [DWIDTH-1:0] memGold [NMEM];

    // The top has already range-checked the index, so only the low bits
    // that address each array are needed here.
    always_ff @(posedge clk) begin
        if (reg_we_i) begin
            regGold[waddr_i[RW-1:0]] <= wdata_i;
        end
        if (mem_we_i) begin
            memGold[waddr_i[MW-1:0]] <= wdata_i;
        end
    end

    assign reg_rdata_o = regGold[reg_raddr_i];
    assign mem_rdata_o = memGold[mem_raddr_i];

endmodule

// File: rtl/arch_state_checker.sv
// arch_state_checker
// Lets the core run for CYCLE_LIMIT cycles (or until halt), then walks every
// register-file entry and data-memory word through the core's debug read
// ports, compares each against preloaded golden values, and reports a
// sticky finish/pass verdict with per-mismatch diagnostics.
// Optional feature macro: ARCH_CHK_HALT_EN - when defined, halt_i high in a
// RUN cycle ends RUN at that edge; when undefined halt_i is ignored.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  leave IDLE and begin RUN
//   halt_i                   core halted
//   gold_we/sel/addr/wdata   golden write port (IDLE only)
//   reg_raddr / reg_rdata    register debug read port (1-cycle latency)
//   mem_raddr / mem_rdata    dmem debug read port (1-cycle latency)
//   run_o                    high during RUN
//   finish, pass             sticky verdict
//   err_count, cycle_count   saturating mismatch count, RUN cycles elapsed
//   mis_valid/sel/idx/got/exp  one-cycle mismatch report
module arch_state_checker
    import arch_chk_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int NREG        = 32,
    parameter int NMEM        = 16,
    parameter int CYCLE_LIMIT = 64,
    parameter int CWIDTH      = 16,
    localparam int IW         = idxWidth((NREG > NMEM) ? NREG : NMEM),
    localparam int RW         = idxWidth(NREG),
    localparam int MW         = idxWidth(NMEM)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              gold_we,
    input  logic              gold_sel,
    input  logic [IW-1:0]     gold_addr,
    input  logic [DWIDTH-1:0] gold_wdata,
    output logic [RW-1:0]     reg_raddr,
    input  logic [DWIDTH-1:0] reg_rdata,
    output logic [MW-1:0]     mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              run_o,
    output logic              finish,
    output logic              pass,
    output logic [CWIDTH-1:0] err_count,
    output logic [CWIDTH-1:0] cycle_count,
    output logic              mis_valid,
    output logic              mis_sel,
    output logic [IW-1:0]     mis_idx,
    output logic [DWIDTH-1:0] mis_got,
    output logic [DWIDTH-1:0] mis_exp
);

    // Separate run counter so the exit decision is independent of CWIDTH.
    localparam int RCW = $clog2(CYCLE_LIMIT + 1);

    state_t            state_q, state_d;
    logic [RCW-1:0]    runCnt_q, runCnt_d;
    logic [CWIDTH-1:0] cycleCnt_q, cycleCnt_d;
    logic [CWIDTH-1:0] errCnt_q, errCnt_d;
    logic [IW-1:0]     scanIdx_q, scanIdx_d;
    logic              cmpValid_q, cmpValid_d;
    logic              cmpSel_q, cmpSel_d;
    logic [IW-1:0]     cmpIdx_q, cmpIdx_d;
    logic              finish_q, finish_d;
    logic              pass_q, pass_d;

    logic              haltReq;
    logic              goldWeReg, goldWeMem;
    logic [DWIDTH-1:0] goldRegRd, goldMemRd;
    logic [DWIDTH-1:0] cmpGot, cmpExp;
    logic              mismatch;

`ifdef ARCH_CHK_HALT_EN
    assign haltReq = halt_i;
`else
    logic unusedHalt;
    assign unusedHalt = halt_i;
    assign haltReq    = 1'b0;
`endif

    // Golden writes only land in IDLE and only for in-range indices.
    assign goldWeReg = (state_q == ST_IDLE) && gold_we && (gold_sel == SEL_REG)
                       && (int'(gold_addr) < NREG);
    assign goldWeMem = (state_q == ST_IDLE) && gold_we && (gold_sel == SEL_MEM)
                       && (int'(gold_addr) < NMEM);

    gold_store #(
        .DWIDTH (DWIDTH),
        .NREG   (NREG),
        .NMEM   (NMEM)
    ) u_gold (
        .clk         (clk),
        .reg_we_i    (goldWeReg),
        .mem_we_i    (goldWeMem),
        .waddr_i     (gold_addr),
        .wdata_i     (gold_wdata),
        .reg_raddr_i (cmpIdx_q[RW-1:0]),
        .mem_raddr_i (cmpIdx_q[MW-1:0]),
        .reg_rdata_o (goldRegRd),
        .mem_rdata_o (goldMemRd)
    );

    // Compare stage: the (sel, idx) registered when the address was issued
    // lines up with the read data returning one cycle later.
    assign cmpGot   = (cmpSel_q == SEL_MEM) ? mem_rdata : reg_rdata;
    assign cmpExp   = (cmpSel_q == SEL_MEM) ? goldMemRd : goldRegRd;
    assign mismatch = cmpValid_q && (cmpGot != cmpExp);

    // Next-state logic. The error count update sits outside the case so a
    // compare in DRAIN is folded into the pass verdict taken on DONE entry.
    always_comb begin
        state_d    = state_q;
        runCnt_d   = runCnt_q;
        cycleCnt_d = cycleCnt_q;
        scanIdx_d  = scanIdx_q;
        cmpValid_d = 1'b0;
        cmpSel_d   = SEL_REG;
        cmpIdx_d   = '0;
        errCnt_d   = errCnt_q;
        if (mismatch && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                runCnt_d   = runCnt_q + 1'b1;
                cycleCnt_d = cycleCnt_q + 1'b1;
                if ((runCnt_q == RCW'(CYCLE_LIMIT - 1)) || haltReq) begin
                    state_d   = ST_SCAN_REG;
                    scanIdx_d = '0;
                end
            end
            ST_SCAN_REG: begin
                cmpValid_d = 1'b1;
                cmpSel_d   = SEL_REG;
                cmpIdx_d   = scanIdx_q;
                if (scanIdx_q == IW'(NREG - 1)) begin
                    state_d   = ST_SCAN_MEM;
                    scanIdx_d = '0;
                end else begin
                    scanIdx_d = scanIdx_q + 1'b1;
                end
            end
            ST_SCAN_MEM: begin
                cmpValid_d = 1'b1;
                cmpSel_d   = SEL_MEM;
                cmpIdx_d   = scanIdx_q;
                if (scanIdx_q == IW'(NMEM - 1)) begin
                    state_d   = ST_DRAIN;
                    scanIdx_d = '0;
                end else begin
                    scanIdx_d = scanIdx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        finish_d = (state_d == ST_DONE);
        pass_d   = finish_d && (errCnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            runCnt_q   <= '0;
            cycleCnt_q <= '0;
            errCnt_q   <= '0;
            scanIdx_q  <= '0;
            cmpValid_q <= 1'b0;
            cmpSel_q   <= SEL_REG;
            cmpIdx_q   <= '0;
            finish_q   <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            runCnt_q   <= runCnt_d;
            cycleCnt_q <= cycleCnt_d;
            errCnt_q   <= errCnt_d;
            scanIdx_q  <= scanIdx_d;
            cmpValid_q <= cmpValid_d;
            cmpSel_q   <= cmpSel_d;
            cmpIdx_q   <= cmpIdx_d;
            finish_q   <= finish_d;
            pass_q     <= pass_d;
        end
    end

    // Read addresses are forced to 0 whenever their scan is not active.
    assign reg_raddr   = (state_q == ST_SCAN_REG) ? scanIdx_q[RW-1:0] : '0;
    assign mem_raddr   = (state_q == ST_SCAN_MEM) ? scanIdx_q[MW-1:0] : '0;
    assign run_o       = (state_q == ST_RUN);
    assign finish      = finish_q;
    assign pass        = pass_q;
    assign err_count   = errCnt_q;
    assign cycle_count = cycleCnt_q;

    // Diagnostics are zero except in the cycle a mismatch is reported.
    assign mis_valid = mismatch;
    assign mis_sel   = mismatch ? cmpSel_q : 1'b0;
    assign mis_idx   = mismatch ? cmpIdx_q : '0;
    assign mis_got   = mismatch ? cmpGot   : '0;
    assign mis_exp   = mismatch ? cmpExp   : '0;

endmodule
